// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate strobe, 640x480@60 H/V counters, HS/VS/DE and frame markers.
// Blanking-first line layout: front porch, sync, back porch, then active video.
// Optional build macro VGA_SYNC_DELAY_EN: HS/VS/DE lag the counters by one pixel
// to line up with a registered RGB stage downstream.
module vga_timing_gen #(
    parameter int unsigned PCK_DIV = 5,
    parameter int unsigned HPERIOD = 800,
    parameter int unsigned HFRONT  = 16,
    parameter int unsigned HWIDTH  = 96,
    parameter int unsigned HBACK   = 48,
    parameter int unsigned VPERIOD = 525,
    parameter int unsigned VFRONT  = 10,
    parameter int unsigned VWIDTH  = 2,
    parameter int unsigned VBACK   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en_o,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       vga_hs_o,
    output logic       vga_vs_o,
    output logic       disp_en_o,
    output logic       fstart_o,
    output logic [7:0] frame_cnt_o
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = 4;
    localparam int unsigned FRM_W = 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HPERIOD - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VPERIOD - 1);
    localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(HFRONT);
    localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(HFRONT + HWIDTH);
    localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(VFRONT);
    localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(VFRONT + VWIDTH);
    localparam logic [CNT_W-1:0] HBLANK   = CNT_W'(HFRONT + HWIDTH + HBACK);
    localparam logic [CNT_W-1:0] VBLANK   = CNT_W'(VFRONT + VWIDTH + VBACK);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             fstart_q, fstart_d;
    logic [FRM_W-1:0] frame_q, frame_d;

    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_src, v_src;
    logic             flag_ld;

    // Clock divider; the strobe is registered and high while the divider sits on its last count
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_en_d = (div_d == DIV_LAST);
    end

    // Position counters and frame marker, advanced only on pixel strobes
    always_comb begin
        h_wrap   = (hcnt_q == H_LAST);
        v_wrap   = (vcnt_q == V_LAST);
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        fstart_d = 1'b0;
        frame_d  = frame_q;
        if (pix_en_q) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + CNT_W'(1);
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + CNT_W'(1);
                if (v_wrap) begin
                    fstart_d = 1'b1;
                    frame_d  = frame_q + FRM_W'(1);
                end
            end
        end
    end

    // Sync/display-enable decode; the delayed build evaluates the counts being left on each strobe
    always_comb begin
`ifdef VGA_SYNC_DELAY_EN
        h_src   = hcnt_q;
        v_src   = vcnt_q;
        flag_ld = pix_en_q;
`else
        h_src   = hcnt_d;
        v_src   = vcnt_d;
        flag_ld = 1'b1;
`endif
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        if (flag_ld) begin
            hs_d = ~((h_src >= HS_LO) && (h_src < HS_HI));
            vs_d = ~((v_src >= VS_LO) && (v_src < VS_HI));
            de_d = (h_src >= HBLANK) && (v_src >= VBLANK);
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            fstart_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fstart_q <= fstart_d;
            frame_q  <= frame_d;
        end
    end

    assign pix_en_o    = pix_en_q;
    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign vga_hs_o    = hs_q;
    assign vga_vs_o    = vs_q;
    assign disp_en_o   = de_q;
    assign fstart_o    = fstart_q;
    assign frame_cnt_o = frame_q;

endmodule
